// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational ALU between two requesters,
// with registered operands, a valid/ready response register and the C Z N V status word.
// Optional build macro ALU_ARB_CARRY_CHAIN_EN feeds the stored carry into chained arithmetic.
module alu_arbiter #(
  parameter int WORD = 16,
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*4-1:0]    req_op,
  input  logic [NREQ*WORD-1:0] req_a,
  input  logic [NREQ*WORD-1:0] req_b,
  input  logic [NREQ-1:0]      req_cin,
  input  logic [NREQ-1:0]      req_upd,
  output logic [3:0]           alu_op,
  output logic [WORD-1:0]      alu_a,
  output logic [WORD-1:0]      alu_b,
  output logic                 alu_cin,
  input  logic [WORD-1:0]      alu_res,
  input  logic [3:0]           alu_flags,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [WORD-1:0]      rsp_res,
  output logic [3:0]           rsp_flags,
  output logic [3:0]           psw
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic            rr_r;
  logic            upd_r;
  logic [1:0]      grant_s;
  logic            gidx_s;
  logic [3:0]      sel_op_s;
  logic [WORD-1:0] sel_a_s;
  logic [WORD-1:0] sel_b_s;
  logic            sel_cin_raw_s;
  logic            sel_cin_s;
  logic            sel_upd_s;

  // A lone requester wins outright; on contention the round-robin pointer decides.
  function automatic logic [1:0] pick_grant(input logic [1:0] valid, input logic rr);
    logic [1:0] g;
    case (valid)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = rr ? 2'b10 : 2'b01;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

  // Grant decode and operand/carry selection for the requester being granted.
  always_comb begin
    grant_s       = pick_grant(req_valid, rr_r);
    gidx_s        = grant_s[1];
    sel_op_s      = gidx_s ? req_op[7:4] : req_op[3:0];
    sel_a_s       = gidx_s ? req_a[2*WORD-1:WORD] : req_a[WORD-1:0];
    sel_b_s       = gidx_s ? req_b[2*WORD-1:WORD] : req_b[WORD-1:0];
    sel_cin_raw_s = gidx_s ? req_cin[1] : req_cin[0];
    sel_upd_s     = gidx_s ? req_upd[1] : req_upd[0];
`ifdef ALU_ARB_CARRY_CHAIN_EN
    // Chained arithmetic takes the carry stored by the previous operation.
    if (sel_cin_raw_s && (sel_op_s[3:2] == 2'b00)) begin
      sel_cin_s = psw[0];
    end else begin
      sel_cin_s = sel_cin_raw_s;
    end
`else
    sel_cin_s = sel_cin_raw_s;
`endif
  end

  // Next-state and combinational accept; ready is offered only in IDLE and never during reset.
  always_comb begin
    state_nxt_s = state_r;
    req_ready   = 2'b00;
    case (state_r)
      IDLE: begin
        if (!rst && (grant_s != 2'b00)) begin
          req_ready   = grant_s;
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: state_nxt_s = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand latch on grant, result/flag capture in EXEC, response release in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_r      <= 1'b0;
      upd_r     <= 1'b0;
      alu_op    <= 4'h0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_cin   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_res   <= '0;
      rsp_flags <= 4'h0;
      psw       <= 4'h0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_s != 2'b00) begin
            alu_op  <= sel_op_s;
            alu_a   <= sel_a_s;
            alu_b   <= sel_b_s;
            alu_cin <= sel_cin_s;
            upd_r   <= sel_upd_s;
            rsp_id  <= gidx_s;
            rr_r    <= ~gidx_s;
          end
        end
        EXEC: begin
          rsp_res   <= alu_res;
          rsp_flags <= alu_flags;
          rsp_valid <= 1'b1;
          if (upd_r) begin
            psw <= alu_flags;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: rsp_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for alu_arbiter with a behavioural ALU attached.
// Expectations for the carry-chain vectors follow ALU_ARB_CARRY_CHAIN_EN.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [1:0]  req_cin;
  logic [1:0]  req_upd;
  logic [3:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_cin;
  logic [15:0] alu_res;
  logic [3:0]  alu_flags;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_res;
  logic [3:0]  rsp_flags;
  logic [3:0]  psw;

  typedef struct packed {
    logic        id;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        upd;
    logic        xcin;
    logic [15:0] res;
    logic [3:0]  flags;
    logic [3:0]  psw;
  } op_t;

  typedef struct packed {
    op_t         o;
    logic [31:0] acc;
  } exp_t;

  op_t         tab [12];
  op_t         mop;
  exp_t        q [$];
  exp_t        head;
  logic        prev_valid;
  logic [31:0] cyc = 32'd0;
  logic [31:0] acc;
  logic [31:0] hs;
  int          total = 0;
  int          bad = 0;
  logic [15:0] bb;
  logic [16:0] sum17;
  logic        fc;
  logic        fv;

  alu_arbiter #(.WORD(16), .NREQ(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_upd(req_upd),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_res(alu_res), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_flags(rsp_flags), .psw(psw)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  // External ALU: block 00 add/sub, other blocks logic ops; flags {V,N,Z,C}.
  always_comb begin
    bb      = (alu_op[1:0] == 2'b01) ? ~alu_b : alu_b;
    sum17   = {1'b0, alu_a} + {1'b0, bb} + {16'h0000, alu_cin};
    alu_res = 16'h0000;
    fc      = 1'b0;
    fv      = 1'b0;
    if (alu_op[3:2] == 2'b00) begin
      alu_res = sum17[15:0];
      fc      = sum17[16];
      fv      = (alu_a[15] == bb[15]) && (alu_res[15] != alu_a[15]);
    end else begin
      case (alu_op[1:0])
        2'b00:   alu_res = alu_a & alu_b;
        2'b01:   alu_res = alu_a | alu_b;
        2'b10:   alu_res = alu_a ^ alu_b;
        default: alu_res = ~alu_a;
      endcase
    end
    alu_flags = {fv, alu_res[15], (alu_res == 16'h0000), fc};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load(input op_t e);
    if (e.id) begin
      req_op[7:4] = e.op; req_a[31:16] = e.a; req_b[31:16] = e.b;
      req_cin[1] = e.cin; req_upd[1] = e.upd; req_valid[1] = 1'b1;
    end else begin
      req_op[3:0] = e.op; req_a[15:0] = e.a; req_b[15:0] = e.b;
      req_cin[0] = e.cin; req_upd[0] = e.upd; req_valid[0] = 1'b1;
    end
  endtask

  task automatic wait_grant(input op_t e, input bit push, output logic [31:0] acc_o);
    int n;
    n = 0;
    acc_o = 32'd0;
    @(negedge clk);
    while ((req_ready == 2'b00) && (n < 40)) begin
      @(negedge clk);
      n++;
    end
    if (req_ready == 2'b00) begin
      total++;
      bad++;
      $display("FAIL grant_timeout: got no req_ready expected grant to %0d", e.id);
    end else begin
      chk("grant_id", {30'd0, req_ready}, e.id ? 32'd2 : 32'd1);
      acc_o = cyc;
      if (push) q.push_back({e, cyc});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_seq(input int base, input int n);
    logic [31:0] a_l;
    load(tab[base]);
    load(tab[base+1]);
    for (int k = 0; k < n; k++) begin
      wait_grant(tab[base+k], 1'b1, a_l);
      if (k + 2 < n) load(tab[base+k+2]);
      else req_valid[tab[base+k].id] = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0) && (n < 40)) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // id, op, a, b, cin, upd, xcin, res, flags, psw
    tab[0]  = '{1'b0, 4'h0, 16'h0003, 16'h0004, 1'b0, 1'b1, 1'b0, 16'h0007, 4'h0, 4'h0};
    tab[1]  = '{1'b1, 4'h0, 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0, 16'h0000, 4'hB, 4'hB};
    tab[2]  = '{1'b0, 4'h4, 16'hF0F0, 16'hFF00, 1'b0, 1'b1, 1'b0, 16'hF000, 4'h4, 4'h4};
    tab[3]  = '{1'b1, 4'h4, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h2, 4'h4};
    tab[4]  = '{1'b0, 4'h0, 16'h0003, 16'h0004, 1'b0, 1'b1, 1'b0, 16'h0007, 4'h0, 4'h0};
    tab[5]  = '{1'b1, 4'h0, 16'hFFFF, 16'h0002, 1'b0, 1'b0, 1'b0, 16'h0001, 4'h1, 4'h0};
    tab[6]  = '{1'b0, 4'h0, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h0000, 4'h3, 4'h3};
    tab[7]  = '{1'b1, 4'h0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0001, 4'h0, 4'h0};
`ifdef ALU_ARB_CARRY_CHAIN_EN
    tab[8]  = '{1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h2, 4'h0};
`else
    tab[8]  = '{1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0001, 4'h0, 4'h0};
`endif
    tab[9]  = '{1'b1, 4'h5, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000, 4'h2, 4'h2};
    tab[10] = '{1'b0, 4'h5, 16'h00FF, 16'h0F00, 1'b0, 1'b1, 1'b0, 16'h0FFF, 4'h0, 4'h0};
    tab[11] = '{1'b1, 4'h0, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h8000, 4'hC, 4'hC};
    mop     = '{1'b0, 4'h0, 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0, 16'h0000, 4'hB, 4'hB};

    rst = 1'b1; rsp_ready = 1'b1; prev_valid = 1'b0;
    req_valid = 2'b00; req_op = 8'h00; req_a = 32'h0; req_b = 32'h0;
    req_cin = 2'b00; req_upd = 2'b00;
    load(tab[0]);
    load(tab[1]);

    // Monitor: compares every presented response cycle against the scoreboard head.
    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          prev_valid = 1'b0;
        end else begin
          chk("ready_onehot0", {31'd0, $onehot0(req_ready)}, 32'd1);
          if (rsp_valid) begin
            chk("ready_outside_idle", {30'd0, req_ready}, 32'd0);
            if (q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL rsp_unexpected: got rsp_valid=1 res=%h expected no response", rsp_res);
            end else begin
              head = q[0];
              if (!prev_valid) chk("latency", cyc - head.acc, 32'd2);
              chk("rsp_id",    {31'd0, rsp_id},    {31'd0, head.o.id});
              chk("rsp_res",   {16'd0, rsp_res},   {16'd0, head.o.res});
              chk("rsp_flags", {28'd0, rsp_flags}, {28'd0, head.o.flags});
              chk("psw",       {28'd0, psw},       {28'd0, head.o.psw});
              chk("alu_op",    {28'd0, alu_op},    {28'd0, head.o.op});
              chk("alu_a",     {16'd0, alu_a},     {16'd0, head.o.a});
              chk("alu_b",     {16'd0, alu_b},     {16'd0, head.o.b});
              chk("alu_cin",   {31'd0, alu_cin},   {31'd0, head.o.xcin});
              if (rsp_ready) void'(q.pop_front());
            end
          end
          prev_valid = rsp_valid;
        end
      end
    join_none

    // Reset held with both requesters pending.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_psw", {28'd0, psw}, 32'd0);
    end
    chk("rst_alu_a", {16'd0, alu_a}, 32'd0);
    chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
    chk("rst_rsp_res", {16'd0, rsp_res}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Round robin with both held valid; first grant after reset goes to requester 0.
    run_seq(0, 4);
    drain();

    // Backpressure: response held 5 cycles while requester 1 waits.
    rsp_ready = 1'b0;
    load(tab[4]);
    wait_grant(tab[4], 1'b1, acc);
    req_valid[0] = 1'b0;
    load(tab[5]);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!rsp_valid && (n < 20)) begin
        @(negedge clk);
        n++;
      end
      chk("bp_rsp_seen", {31'd0, rsp_valid}, 32'd1);
    end
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    hs = cyc;
    wait_grant(tab[5], 1'b1, acc);
    chk("idle_after_handshake", acc, hs + 32'd1);
    req_valid[1] = 1'b0;
    drain();

    // Carry chain across separate requests.
    run_seq(6, 4);
    drain();

    // Reset during EXEC discards the operation and restarts the pointer at 0.
    load(mop);
    wait_grant(mop, 1'b0, acc);
    req_valid = 2'b00;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_psw", {28'd0, psw}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_seq(10, 2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU of the multi-cycle X-Makina datapath between two requesters: 0 = execute sequencer, 1 = address/auxiliary unit.
- Grants one requester at a time and registers its operands into the ALU inputs.
- Captures the ALU result and flags into a response register with a valid/ready handshake.
- Maintains the architectural C Z N V status flags on request.

Parameters:
- WORD, 16, datapath width of operands and result.
- NREQ, 2, number of requesters; fixed at 2 for this revision.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  NREQ  per-requester request strobe
- req_ready  output  NREQ  per-requester accept (one-hot or zero)
- req_op  input  NREQ*4  per-requester ALU opcode; [3:2] block, [1:0] sub-op
- req_a  input  NREQ*WORD  per-requester operand A
- req_b  input  NREQ*WORD  per-requester operand B
- req_cin  input  NREQ  per-requester carry-in
- req_upd  input  NREQ  1 = write resulting flags to psw
- alu_op  output  4  to ALU op
- alu_a  output  WORD  to ALU a
- alu_b  output  WORD  to ALU b
- alu_cin  output  1  to ALU cin
- alu_res  input  WORD  from ALU res
- alu_flags  input  4  from ALU flags, bit order C Z N V (bit0 = C)
- rsp_valid  output  1  response available
- rsp_ready  input  1  response consumer accept
- rsp_id  output  1  index of requester owning the response
- rsp_res  output  WORD  captured result
- rsp_flags  output  4  captured flags
- psw  output  4  architectural status flags C Z N V

Behaviour:
- Reset is synchronous, active-high, single clock. Reset values:
  - state = IDLE
  - all outputs 0: req_ready, alu_op, alu_a, alu_b, alu_cin, rsp_valid, rsp_id, rsp_res, rsp_flags, psw
  - round-robin pointer = 0 (requester 0 preferred first)
- Operand registers drive alu_* directly; alu_* change only on grant.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational = grant & {IDLE}.
  - grant: if only one req_valid, that one; if both, the one selected by the rr pointer.
  - On grant: latch op/a/b/cin/upd into operand regs, latch rsp_id, toggle rr pointer to the other requester, go EXEC.
  - With no request, stay in IDLE; req_ready = 0.
- EXEC (one cycle, ALU settles from registered inputs):
  - rsp_res <= alu_res, rsp_flags <= alu_flags, rsp_valid <= 1.
  - If the latched upd = 1, psw <= alu_flags; otherwise psw is unchanged.
  - Go RESP.
- RESP:
  - Hold rsp_* stable while rsp_valid && !rsp_ready.
  - On rsp_ready: rsp_valid <= 0, go IDLE.
  - No new grant in the handshake cycle.
- Latency: request accepted in cycle N -> rsp_valid high in cycle N+2. Minimum 3 cycles per operation.
- req_ready is never asserted outside IDLE. A requester must hold req_valid and its operands until it sees ready.
- Simultaneous requests: strict alternation. Neither requester wins twice in a row while the other is pending.
- Reset mid-operation (EXEC or RESP): operation discarded; psw not updated if reset coincides with EXEC.
- rsp_ready asserted while rsp_valid = 0 is ignored.
- No arithmetic is performed here. Flag ordering is passed through unaltered.

Optional Feature:
- Macro: ALU_ARB_CARRY_CHAIN_EN.
- Defined:
  - A grant latches alu_cin = psw[0] (the stored C flag) instead of req_cin whenever req_cin = 1 and the opcode block [3:2] = 00 (arithmetic).
  - This enables multi-word add/sub chains across separate requests.
  - psw[0] is the value at the grant cycle.
- Undefined: alu_cin = req_cin always; psw is used only as an output.

Test Plan:
- Reset behaviour: hold rst 2 cycles with req_valid = 2'b11 -> req_ready = 0, rsp_valid = 0, psw = 0 throughout; first grant after rst release goes to requester 0.
- Single request: req0 op = 0000, a = 16'h0003, b = 16'h0004, upd = 1, accepted cycle N -> rsp_valid at N+2, rsp_id = 0, rsp_res = 16'h0007, psw updated to the captured ALU flags.
- Round robin: both requesters held valid for 4 operations, rsp_ready tied 1 -> grant order 0, 1, 0, 1; req_ready one-hot, only in IDLE.
- Backpressure: rsp_ready = 0 for 5 cycles after rsp_valid -> rsp_res, rsp_flags, rsp_id stable; no req_ready; on rsp_ready = 1 the FSM returns to IDLE the next cycle.
- Flag update gating: req1 with upd = 0 producing zero result (a = b = 16'h0000, logic op) -> rsp_flags Z = 1; psw unchanged from its prior value.
- Carry chain with ALU_ARB_CARRY_CHAIN_EN defined:
  - Op 1: add a = 16'hFFFF, b = 16'h0001, upd = 1 -> psw C = 1.
  - Op 2: add with req_cin = 1, a = b = 16'h0000 -> alu_cin = 1 (psw C), rsp_res = 16'h0001.
  - Same sequence with the macro undefined -> alu_cin follows req_cin.
